confrontatore: RTL and testbench
================================

Name: confrontatore

Overview:
- N-bit equality comparator: out=0 when inputs are equal, out=1 when they differ (OR-reduction of bitwise XOR).
- Core use: N=1 inside the level-transition indicator. It compares the registered sender-level bit with the registered mod-2 acknowledge counter, so out=1 means an event is pending.
- Adds a registered copy of the result and a one-cycle pulse on each change of that registered copy, for synchronous consumers.

Parameters:
- N, 1, width of both compared operands (legal range 1..64).

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- a  in  N  first operand (level-transition use: registered sender level).
- b  in  N  second operand (level-transition use: registered counter).
- out  out  N=any,1  combinational result; 1 iff a != b.
- eq  out  1  combinational; always the complement of out.
- diff_mask  out  N  combinational bitwise a XOR b (debug/visibility).
- out_q  out  1  out registered on clock.
- toggle  out  1  registered pulse; high one cycle when out_q changes value.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-low (reset_n).
- Combinational path:
  - out = |(a ^ b), with zero cycles of latency.
  - It does not depend on clock or reset_n.
  - It is valid whenever a and b are stable, including while reset_n=0.
- eq = ~out at all times. diff_mask = a ^ b, bit for bit.
- Registered path, on posedge clock:
  - If reset_n=0: out_q<=0, toggle<=0.
  - Otherwise: out_q<=out, toggle<=(out != out_q).
- Latency:
  - out_q follows out one cycle later.
  - toggle goes high in the same cycle that out_q changes and lasts exactly one cycle per change.
- Reset mid-operation:
  - out_q and toggle clear on the first clock edge with reset_n=0.
  - On the first clock edge after release, out_q loads the current out. If that value is 1, toggle pulses (0->1 change).
- Simultaneous change of a and b:
  - Only the final values matter; no hazard handling is required.
  - Example: a and b both flipping 0->1 in one cycle leaves out=0 and produces no toggle.
- X/Z on inputs: no special handling; do not mask.
- No internal delays (#) in RTL. Timing abstraction, e.g. "2tp", belongs to the surrounding models.
- Width rules:
  - a and b have identical width N; no sign or magnitude semantics.
  - For N=1, out reduces to a XOR b.

Decomposition:
- Shared package conf_pkg holds CONF_DEFAULT_N = 1 and CONF_MAX_N = 64, with a static assertion on the N range.
- One sub-module, conf_or_tree: parameterized, balanced binary OR-reduction tree over diff_mask. It is combinational only, with log2(N) levels.
- The top level instantiates conf_or_tree and holds the out_q/toggle flops.

Test Plan:
- N=1, reset_n=0 for 2 cycles with a=1, b=0 -> out=1 and eq=0 immediately; out_q=0, toggle=0 during reset. After release: out_q=1 and toggle=1 on the first edge; toggle=0 on the next edge.
- N=1 handshake: a toggles 0->1 (out=1), then 3 cycles later b toggles 0->1 -> out 1->0 combinationally; out_q drops one edge later; toggle pulses once at each transition.
- N=1, a and b both flip 0->1 in the same cycle -> out stays 0, out_q stays 0, toggle never asserts.
- N=8, a=8'hA5, b=8'hA5 -> out=0, eq=1, diff_mask=0. Then b=8'hA4 -> out=1, diff_mask=8'h01. Then b=8'h25 -> diff_mask=8'h80.
- N=64, walking single-bit difference over all 64 positions -> out=1 for every position; out=0 when the operands are restored to equal.
- Mid-run reset: with out_q=1, assert reset_n=0 for one edge -> out_q=0, toggle=0. Release with a!=b -> out_q=1, toggle=1 for one cycle.

Source files
------------

// File: rtl/conf_pkg.sv
// Shared constants and parameter checks for the confrontatore equality comparator.
package conf_pkg;

  localparam int CONF_DEFAULT_N = 1;
  localparam int CONF_MAX_N     = 64;

  function automatic bit conf_n_legal(input int n);
    return (n >= 1) && (n <= CONF_MAX_N);
  endfunction

endpackage

// File: rtl/conf_or_tree.sv
// Balanced binary OR-reduction tree; recursion splits the vector in halves,
// giving ceil(log2(N)) levels of 2-input OR.
module conf_or_tree
  import conf_pkg::*;
#(
  parameter int N = CONF_DEFAULT_N
) (
  input  logic [N-1:0] bits_i,
  output logic         any_o
);

  generate
    if (N == 1) begin : g_leaf
      assign any_o = bits_i[0];
    end else begin : g_node
      localparam int NL = N / 2;
      localparam int NR = N - NL;

      logic any_lo;
      logic any_hi;

      conf_or_tree #(.N(NL)) u_lo (
        .bits_i (bits_i[NL-1:0]),
        .any_o  (any_lo)
      );

      conf_or_tree #(.N(NR)) u_hi (
        .bits_i (bits_i[N-1:NL]),
        .any_o  (any_hi)
      );

      assign any_o = any_lo | any_hi;
    end
  endgenerate

endmodule

// File: rtl/confrontatore.sv
// N-bit inequality detector: combinational out/eq/diff_mask plus a registered
// copy of out and a one-cycle pulse on every change of that copy.
module confrontatore
  import conf_pkg::*;
#(
  parameter int N = CONF_DEFAULT_N
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out,
  output logic         eq,
  output logic [N-1:0] diff_mask,
  output logic         out_q,
  output logic         toggle
);

  generate
    if (!conf_n_legal(N)) begin : g_bad_n
      $error("confrontatore: N=%0d outside 1..%0d", N, CONF_MAX_N);
    end
  endgenerate

  logic [N-1:0] diff_s;
  logic         out_s;
  logic         outreg_d;
  logic         outreg_q;
  logic         toggle_d;
  logic         toggle_q;

  assign diff_s = a ^ b;

  conf_or_tree #(.N(N)) u_or_tree (
    .bits_i (diff_s),
    .any_o  (out_s)
  );

  // toggle marks the edge at which the registered copy takes a new value
  always_comb begin
    outreg_d = out_s;
    toggle_d = (out_s != outreg_q);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      outreg_q <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      outreg_q <= outreg_d;
      toggle_q <= toggle_d;
    end
  end

  assign out       = out_s;
  assign eq        = ~out_s;
  assign diff_mask = diff_s;
  assign out_q     = outreg_q;
  assign toggle    = toggle_q;

endmodule

// File: tb/tb_confrontatore.sv
// Self-checking bench: three instances (N=1, 8, 64) against a behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_confrontatore;

  logic        clock;
  logic        reset_n;
  logic        a1, b1;
  logic [7:0]  a8, b8;
  logic [63:0] a64, b64;

  logic        out1, eq1, dm1, outq1, tog1;
  logic        out8, eq8, outq8, tog8;
  logic [7:0]  dm8;
  logic        out64, eq64, outq64, tog64;
  logic [63:0] dm64;

  int checks = 0;
  int errors = 0;

  confrontatore #(.N(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .a(a1), .b(b1),
    .out(out1), .eq(eq1), .diff_mask(dm1), .out_q(outq1), .toggle(tog1)
  );

  confrontatore #(.N(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .a(a8), .b(b8),
    .out(out8), .eq(eq8), .diff_mask(dm8), .out_q(outq8), .toggle(tog8)
  );

  confrontatore #(.N(64)) dut64 (
    .clock(clock), .reset_n(reset_n), .a(a64), .b(b64),
    .out(out64), .eq(eq64), .diff_mask(dm64), .out_q(outq64), .toggle(tog64)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: out_q holds whether the operands differed at the last
  // edge; toggle says that verdict changed at this edge. Reset clears both.
  bit m_valid = 1'b0;
  bit m_q1, m_t1, m_q8, m_t8, m_q64, m_t64;

  always @(posedge clock) begin
    bit n1, n8, n64;
    n1  = reset_n ? (a1  != b1)  : 1'b0;
    n8  = reset_n ? (a8  != b8)  : 1'b0;
    n64 = reset_n ? (a64 != b64) : 1'b0;
    m_t1  <= reset_n && (n1  != m_q1);
    m_t8  <= reset_n && (n8  != m_q8);
    m_t64 <= reset_n && (n64 != m_q64);
    m_q1  <= n1;
    m_q8  <= n8;
    m_q64 <= n64;
    if (!reset_n) m_valid <= 1'b1;
  end

  // Compare process: every negedge, combinational and registered outputs.
  always @(negedge clock) begin
    chk("out1",  {63'd0, out1},  {63'd0, (a1 != b1)});
    chk("eq1",   {63'd0, eq1},   {63'd0, (a1 == b1)});
    chk("dm1",   {63'd0, dm1},   {63'd0, (a1 ^ b1)});
    chk("out8",  {63'd0, out8},  {63'd0, (a8 != b8)});
    chk("eq8",   {63'd0, eq8},   {63'd0, (a8 == b8)});
    chk("dm8",   {56'd0, dm8},   {56'd0, (a8 ^ b8)});
    chk("out64", {63'd0, out64}, {63'd0, (a64 != b64)});
    chk("eq64",  {63'd0, eq64},  {63'd0, (a64 == b64)});
    chk("dm64",  dm64,           a64 ^ b64);
    if (m_valid) begin
      chk("outq1",  {63'd0, outq1},  {63'd0, m_q1});
      chk("tog1",   {63'd0, tog1},   {63'd0, m_t1});
      chk("outq8",  {63'd0, outq8},  {63'd0, m_q8});
      chk("tog8",   {63'd0, tog8},   {63'd0, m_t8});
      chk("outq64", {63'd0, outq64}, {63'd0, m_q64});
      chk("tog64",  {63'd0, tog64},  {63'd0, m_t64});
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_reg1(input string name, input bit q, input bit t);
    chk({name, "_outq"}, {63'd0, outq1}, {63'd0, q});
    chk({name, "_tog"},  {63'd0, tog1},  {63'd0, t});
  endtask

  initial begin
    reset_n = 1'b0;
    a1 = 1'b1; b1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    a64 = 64'd0; b64 = 64'd0;

    // reset with a!=b: combinational result is live during reset
    #1;
    chk("rst_out", {63'd0, out1}, 64'd1);
    chk("rst_eq",  {63'd0, eq1},  64'd0);
    step(); chk_reg1("rst_e1", 1'b0, 1'b0);
    step(); chk_reg1("rst_e2", 1'b0, 1'b0);
    reset_n = 1'b1;
    step(); chk_reg1("rel_e1", 1'b1, 1'b1);
    step(); chk_reg1("rel_e2", 1'b1, 1'b0);

    // handshake: a rises, b follows three cycles later
    a1 = 1'b0; b1 = 1'b0;
    step(); chk_reg1("hs_idle", 1'b0, 1'b1);
    step(); chk_reg1("hs_idle2", 1'b0, 1'b0);
    a1 = 1'b1; #1;
    chk("hs_out_up", {63'd0, out1}, 64'd1);
    step(); chk_reg1("hs_a_e1", 1'b1, 1'b1);
    step(); chk_reg1("hs_a_e2", 1'b1, 1'b0);
    step(); chk_reg1("hs_a_e3", 1'b1, 1'b0);
    b1 = 1'b1; #1;
    chk("hs_out_dn", {63'd0, out1}, 64'd0);
    step(); chk_reg1("hs_b_e1", 1'b0, 1'b1);
    step(); chk_reg1("hs_b_e2", 1'b0, 1'b0);

    // simultaneous flip: no event
    a1 = 1'b0; b1 = 1'b0;
    step(); step();
    a1 = 1'b1; b1 = 1'b1; #1;
    chk("sim_out", {63'd0, out1}, 64'd0);
    step(); chk_reg1("sim_e1", 1'b0, 1'b0);
    step(); chk_reg1("sim_e2", 1'b0, 1'b0);

    // N=8 literal patterns
    a8 = 8'hA5; b8 = 8'hA5; #1;
    chk("n8_eq_out", {63'd0, out8}, 64'd0);
    chk("n8_eq_eq",  {63'd0, eq8},  64'd1);
    chk("n8_eq_dm",  {56'd0, dm8},  64'd0);
    step();
    b8 = 8'hA4; #1;
    chk("n8_lsb_out", {63'd0, out8}, 64'd1);
    chk("n8_lsb_dm",  {56'd0, dm8},  64'h01);
    step();
    b8 = 8'h25; #1;
    chk("n8_msb_dm",  {56'd0, dm8},  64'h80);
    step();

    // N=64 walking single-bit difference
    for (int i = 0; i < 64; i++) begin
      logic [63:0] one;
      one = 64'd1;
      a64 = {$urandom, $urandom};
      b64 = a64 ^ (one << i);
      #1;
      chk($sformatf("walk%0d", i), {63'd0, out64}, 64'd1);
      step();
    end
    b64 = a64; #1;
    chk("walk_restore", {63'd0, out64}, 64'd0);
    step();

    // mid-run reset with out_q=1
    a1 = 1'b1; b1 = 1'b0;
    step(); step();
    chk("mid_pre_outq", {63'd0, outq1}, 64'd1);
    reset_n = 1'b0;
    step(); chk_reg1("mid_rst", 1'b0, 1'b0);
    reset_n = 1'b1;
    step(); chk_reg1("mid_rel1", 1'b1, 1'b1);
    step(); chk_reg1("mid_rel2", 1'b1, 1'b0);

    // randomized traffic, model-checked every negedge
    for (int c = 0; c < 400; c++) begin
      reset_n = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 2) != 0) a1 = $urandom_range(0, 1);
      if ($urandom_range(0, 2) != 0) b1 = $urandom_range(0, 1);
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 1) != 0) ? a8 : (a8 ^ (8'd1 << $urandom_range(0, 7)));
      a64 = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: b64 = a64;
        1: b64 = a64 ^ (64'd1 << $urandom_range(0, 63));
        default: b64 = {$urandom, $urandom};
      endcase
      step();
    end

    reset_n = 1'b1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
